lda_token_sched: RTL and testbench
==================================

Name: lda_token_sched

Overview:
- Sequences one Gibbs-sampling sweep of the LDA accelerator, token by token, for N_ITERS passes.
- For each token it:
  - reads (word, doc, old topic) from the external token store;
  - broadcasts the token to all per-topic count memories;
  - gathers their valid pulses and hands control to the sampler;
  - forwards the sampled topic back to the count memories;
  - waits for every memory to finish, then writes the new assignment back.
- Sits between the token store, the N_TOPICS topic_mem instances and the sampler.

Parameters:
- N_TOPICS, 16, number of topic_mem instances; sets the width of the valid/done vectors.
- TOK_AW, 16, token-store address width.
- ITER_W, 16, iteration counter width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- i_start  in  1  pulse; begin a run. Ignored unless in IDLE.
- i_num_tokens  in  TOK_AW  tokens per pass; sampled on i_start.
- i_num_iters  in  ITER_W  number of passes; sampled on i_start.
- o_tok_ren  out  1  token-store read enable. Read data is valid the cycle after.
- o_tok_addr  out  TOK_AW  token index.
- i_tok_word  in  32  word id.
- i_tok_doc  in  32  document id.
- i_tok_topic  in  32  current topic of the token.
- o_z_wen  out  1  token-store topic write enable, 1-cycle pulse.
- o_z_wdata  out  32  new topic; the write address is o_tok_addr.
- o_tm_start  out  1  1-cycle start pulse to all topic_mems.
- o_tm_topic  out  32  old topic, broadcast.
- o_tm_word  out  32  word, broadcast.
- o_tm_ndoc  out  32  document, broadcast.
- o_tm_new_topic  out  32  sampled topic, broadcast.
- o_tm_topic_valid  out  1  1-cycle pulse marking o_tm_new_topic.
- i_tm_valid  in  N_TOPICS  per-topic count-valid pulses.
- i_tm_done  in  N_TOPICS  per-topic done pulses.
- o_samp_start  out  1  1-cycle pulse; counts are ready at the sampler.
- i_samp_valid  in  1  sampler result valid, 1-cycle pulse.
- i_samp_topic  in  32  sampled topic.
- o_busy  out  1  high whenever not in IDLE.
- o_done  out  1  1-cycle pulse at end of run.
- o_err  out  1  sticky; set on an out-of-range sampled topic; cleared by rst or i_start.
- o_tok_cnt  out  TOK_AW  current token index.
- o_iter_cnt  out  ITER_W  current pass index.

Behaviour:
- Reset: state IDLE; every output, counter and internal register cleared to 0.
- States: IDLE, FETCH, LOAD, START, GATHER, SAMPLE, COMMIT, DRAIN, WB, NEXT, FIN.
- IDLE:
  - on i_start, latch i_num_tokens and i_num_iters, clear o_err, zero both counters;
  - if either latched value is 0, go to FIN; otherwise go to FETCH.
- FETCH: o_tok_ren=1, o_tok_addr=o_tok_cnt; go to LOAD.
- LOAD: register word, doc and old topic onto the o_tm_* buses; clear the valid and done masks; go to START.
- START: o_tm_start=1 for this cycle only; go to GATHER.
  - o_tm_topic, o_tm_word and o_tm_ndoc stay stable from LOAD until leaving WB.
- GATHER:
  - vmask |= i_tm_valid every cycle, including the START cycle;
  - done_mask |= i_tm_done every cycle;
  - when vmask is all ones, go to SAMPLE.
- SAMPLE:
  - o_samp_start=1 on the first SAMPLE cycle only, then wait for i_samp_valid;
  - on i_samp_valid, capture i_samp_topic;
  - if the captured value is >= N_TOPICS, set o_err and substitute the old topic;
  - go to COMMIT.
- COMMIT:
  - drive o_tm_new_topic with the captured value, before or in this cycle;
  - o_tm_topic_valid=1 for exactly this cycle;
  - o_tm_new_topic stays stable until leaving WB, so downstream falling-edge capture is safe;
  - go to DRAIN.
- DRAIN:
  - done_mask |= i_tm_done;
  - when done_mask is all ones, go to WB.
- WB: o_z_wen=1 for one cycle, o_z_wdata=new topic, o_tok_addr=current token; go to NEXT.
- NEXT:
  - if o_tok_cnt == num_tokens-1: set o_tok_cnt=0 and increment o_iter_cnt;
    - if the incremented value == num_iters, go to FIN; otherwise go to FETCH;
  - else increment o_tok_cnt and go to FETCH.
- FIN: o_done=1 for one cycle; go to IDLE.
- Pulses arriving outside GATHER/DRAIN: i_tm_valid and i_tm_done are still OR-ed into their masks between LOAD and WB; they are ignored in other states.
- i_samp_valid outside SAMPLE is ignored.
- Per-token latency with immediate responders: 9 cycles + sampler latency + done latency.
- i_start while busy is ignored; latched parameters do not change.
- rst mid-operation: return to IDLE next edge; no o_z_wen is issued for the in-flight token.
- Counters do not wrap beyond their latched limits.

Test Plan:
- N_TOPICS=4, 2 tokens, 1 iter; tokens (w=3,d=1,z=0), (w=5,d=2,z=2); behavioural topic_mems respond valid 2 cycles after start and done 3 cycles after topic_valid; sampler returns 1 then 3.
  - Required: z writes to addresses 0 and 1 with data 1 and 3.
  - Required: exactly 2 o_tm_start pulses and 2 o_samp_start pulses.
  - Required: one o_done pulse; final o_iter_cnt=1.
- i_num_tokens=0, i_num_iters=5.
  - Required: o_done exactly 2 cycles after i_start; no o_tok_ren, o_tm_start or o_z_wen.
- Staggered i_tm_valid, one bit per cycle in order 3,0,2,1.
  - Required: o_samp_start occurs only the cycle after bit 1 arrives.
  - Repeat with all bits arriving in the START cycle; required: no deadlock.
- Sampler returns 7 with N_TOPICS=4, old topic 2.
  - Required: o_err=1; o_tm_new_topic=2; z write data=2; o_err stays high until the next i_start.
- 3 tokens, 2 iters.
  - Required: o_tok_addr sequence 0,1,2,0,1,2; o_done after the 6th write; o_iter_cnt=2.
- Assert rst during SAMPLE, then issue i_start pulses during a run.
  - Required: rst returns to IDLE with all outputs 0 and no pending write.
  - Required: an i_start while busy leaves counters and latched limits unchanged.

Source files
------------

// File: rtl/lda_token_sched.sv
// Token scheduler for one LDA Gibbs sweep: fetches each token, fans it out to the
// per-topic count memories, hands off to the sampler and writes the new topic back.
module lda_token_sched #(
  parameter int N_TOPICS = 16,
  parameter int TOK_AW   = 16,
  parameter int ITER_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [TOK_AW-1:0]   i_num_tokens,
  input  logic [ITER_W-1:0]   i_num_iters,
  output logic                o_tok_ren,
  output logic [TOK_AW-1:0]   o_tok_addr,
  input  logic [31:0]         i_tok_word,
  input  logic [31:0]         i_tok_doc,
  input  logic [31:0]         i_tok_topic,
  output logic                o_z_wen,
  output logic [31:0]         o_z_wdata,
  output logic                o_tm_start,
  output logic [31:0]         o_tm_topic,
  output logic [31:0]         o_tm_word,
  output logic [31:0]         o_tm_ndoc,
  output logic [31:0]         o_tm_new_topic,
  output logic                o_tm_topic_valid,
  input  logic [N_TOPICS-1:0] i_tm_valid,
  input  logic [N_TOPICS-1:0] i_tm_done,
  output logic                o_samp_start,
  input  logic                i_samp_valid,
  input  logic [31:0]         i_samp_topic,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [TOK_AW-1:0]   o_tok_cnt,
  output logic [ITER_W-1:0]   o_iter_cnt
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_LOAD   = 4'd2;
  localparam logic [3:0] S_START  = 4'd3;
  localparam logic [3:0] S_GATHER = 4'd4;
  localparam logic [3:0] S_SAMPLE = 4'd5;
  localparam logic [3:0] S_COMMIT = 4'd6;
  localparam logic [3:0] S_DRAIN  = 4'd7;
  localparam logic [3:0] S_WB     = 4'd8;
  localparam logic [3:0] S_NEXT   = 4'd9;
  localparam logic [3:0] S_FIN    = 4'd10;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] doc;
    logic [31:0] topic;
  } tok_t;

  logic [3:0]          state_q, state_d;
  logic [TOK_AW-1:0]   ntok_q, ntok_d, tok_cnt_q, tok_cnt_d;
  logic [ITER_W-1:0]   niter_q, niter_d, iter_cnt_q, iter_cnt_d, iter_inc;
  tok_t                tok_q, tok_d;
  logic [31:0]         new_q, new_d;
  logic [N_TOPICS-1:0] vmask_q, vmask_d, dmask_q, dmask_d;
  logic                err_q, err_d, first_q, first_d, done_q;
  logic                in_window;

  // Count-memory pulses are accumulated anywhere from START through WB so early
  // responders are never lost.
  assign in_window = (state_q >= S_START) && (state_q <= S_WB);
  assign iter_inc  = iter_cnt_q + ITER_W'(1);

  always_comb begin
    state_d    = state_q;
    ntok_d     = ntok_q;
    niter_d    = niter_q;
    tok_cnt_d  = tok_cnt_q;
    iter_cnt_d = iter_cnt_q;
    tok_d      = tok_q;
    new_d      = new_q;
    err_d      = err_q;
    first_d    = first_q;
    vmask_d    = vmask_q;
    dmask_d    = dmask_q;
    if (in_window) begin
      vmask_d = vmask_q | i_tm_valid;
      dmask_d = dmask_q | i_tm_done;
    end
    case (state_q)
      S_IDLE: if (i_start) begin
        ntok_d     = i_num_tokens;
        niter_d    = i_num_iters;
        err_d      = 1'b0;
        tok_cnt_d  = '0;
        iter_cnt_d = '0;
        state_d    = (i_num_tokens == '0 || i_num_iters == '0) ? S_FIN : S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        tok_d   = '{word: i_tok_word, doc: i_tok_doc, topic: i_tok_topic};
        vmask_d = '0;
        dmask_d = '0;
        state_d = S_START;
      end
      S_START: state_d = S_GATHER;
      S_GATHER: if (&vmask_d) begin
        first_d = 1'b1;
        state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        first_d = 1'b0;
        if (i_samp_valid) begin
          // Out-of-range topics keep the token where it was and flag the run.
          if (i_samp_topic >= 32'(N_TOPICS)) begin
            new_d = tok_q.topic;
            err_d = 1'b1;
          end else begin
            new_d = i_samp_topic;
          end
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_DRAIN;
      S_DRAIN:  if (&dmask_d) state_d = S_WB;
      S_WB:     state_d = S_NEXT;
      S_NEXT: begin
        if (tok_cnt_q == ntok_q - TOK_AW'(1)) begin
          tok_cnt_d  = '0;
          iter_cnt_d = iter_inc;
          state_d    = (iter_inc == niter_q) ? S_FIN : S_FETCH;
        end else begin
          tok_cnt_d = tok_cnt_q + TOK_AW'(1);
          state_d   = S_FETCH;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ntok_q     <= '0;
      niter_q    <= '0;
      tok_cnt_q  <= '0;
      iter_cnt_q <= '0;
      tok_q      <= '0;
      new_q      <= '0;
      err_q      <= 1'b0;
      first_q    <= 1'b0;
      vmask_q    <= '0;
      dmask_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ntok_q     <= ntok_d;
      niter_q    <= niter_d;
      tok_cnt_q  <= tok_cnt_d;
      iter_cnt_q <= iter_cnt_d;
      tok_q      <= tok_d;
      new_q      <= new_d;
      err_q      <= err_d;
      first_q    <= first_d;
      vmask_q    <= vmask_d;
      dmask_q    <= dmask_d;
      done_q     <= (state_q == S_FIN);
    end
  end

  assign o_tok_ren        = (state_q == S_FETCH);
  assign o_tok_addr       = tok_cnt_q;
  assign o_z_wen          = (state_q == S_WB);
  assign o_z_wdata        = new_q;
  assign o_tm_start       = (state_q == S_START);
  assign o_tm_topic       = tok_q.topic;
  assign o_tm_word        = tok_q.word;
  assign o_tm_ndoc        = tok_q.doc;
  assign o_tm_new_topic   = new_q;
  assign o_tm_topic_valid = (state_q == S_COMMIT);
  assign o_samp_start     = (state_q == S_SAMPLE) && first_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_done           = done_q;
  assign o_err            = err_q;
  assign o_tok_cnt        = tok_cnt_q;
  assign o_iter_cnt       = iter_cnt_q;

endmodule

// File: tb/tb_lda_token_sched.sv
// Bench for lda_token_sched: behavioural token store, topic memories and sampler,
// with expected writes/broadcasts queued at launch and checked as they appear.
module tb_lda_token_sched;
  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_num_tokens = '0;
  logic [15:0] i_num_iters = '0;
  logic        o_tok_ren, o_z_wen, o_tm_start, o_tm_topic_valid, o_samp_start;
  logic        o_busy, o_done, o_err;
  logic [15:0] o_tok_addr, o_tok_cnt, o_iter_cnt;
  logic [31:0] i_tok_word = '0, i_tok_doc = '0, i_tok_topic = '0, i_samp_topic = '0;
  logic [31:0] o_z_wdata, o_tm_topic, o_tm_word, o_tm_ndoc, o_tm_new_topic;
  logic [NT-1:0] i_tm_valid = '0, i_tm_done = '0;
  logic        i_samp_valid = 1'b0;

  lda_token_sched #(.N_TOPICS(NT), .TOK_AW(16), .ITER_W(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_tokens(i_num_tokens),
    .i_num_iters(i_num_iters), .o_tok_ren(o_tok_ren), .o_tok_addr(o_tok_addr),
    .i_tok_word(i_tok_word), .i_tok_doc(i_tok_doc), .i_tok_topic(i_tok_topic),
    .o_z_wen(o_z_wen), .o_z_wdata(o_z_wdata), .o_tm_start(o_tm_start),
    .o_tm_topic(o_tm_topic), .o_tm_word(o_tm_word), .o_tm_ndoc(o_tm_ndoc),
    .o_tm_new_topic(o_tm_new_topic), .o_tm_topic_valid(o_tm_topic_valid),
    .i_tm_valid(i_tm_valid), .i_tm_done(i_tm_done), .o_samp_start(o_samp_start),
    .i_samp_valid(i_samp_valid), .i_samp_topic(i_samp_topic), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_tok_cnt(o_tok_cnt), .o_iter_cnt(o_iter_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int n_ren = 0, n_tms = 0, n_ss = 0, n_done = 0, n_wen = 0;
  int b_ren, b_tms, b_ss, b_done, b_wen;
  int start_cyc, b1_cyc = -100;
  bit stag = 1'b0;

  logic [31:0] mem_w [8], mem_d [8], mem_z [8];
  int vdel [NT], ddel [NT], slat = 1;
  int vd [NT] = '{-1, -1, -1, -1};
  int dd [NT] = '{-1, -1, -1, -1};
  int sd = -1;

  logic [31:0] samp_q [$];
  logic [95:0] tq [$];
  logic [31:0] ntq [$];
  logic [63:0] zq [$];

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  // Token store, topic memories and sampler, driven away from the active edge.
  always @(negedge clk) begin
    i_tm_valid   = '0;
    i_tm_done    = '0;
    i_samp_valid = 1'b0;
    if (o_tok_ren) begin
      i_tok_word  = mem_w[o_tok_addr[2:0]];
      i_tok_doc   = mem_d[o_tok_addr[2:0]];
      i_tok_topic = mem_z[o_tok_addr[2:0]];
    end
    if (o_tm_start) for (int i = 0; i < NT; i++) vd[i] = vdel[i];
    if (o_tm_topic_valid) for (int i = 0; i < NT; i++) dd[i] = ddel[i];
    if (o_samp_start) sd = slat;
    for (int i = 0; i < NT; i++) begin
      if (vd[i] == 0) begin
        i_tm_valid[i] = 1'b1;
        vd[i] = -1;
        if (i == 1) b1_cyc = cyc;
      end else if (vd[i] > 0) vd[i]--;
      if (dd[i] == 0) begin
        i_tm_done[i] = 1'b1;
        dd[i] = -1;
      end else if (dd[i] > 0) dd[i]--;
    end
    if (sd == 0) begin
      i_samp_valid = 1'b1;
      i_samp_topic = (samp_q.size() > 0) ? samp_q.pop_front() : 32'd0;
      sd = -1;
    end else if (sd > 0) sd--;
  end

  // Scoreboard side: compare each DUT event against the queued expectation.
  always @(negedge clk) if (!rst) begin
    logic [95:0] e;
    if (o_tok_ren) n_ren++;
    if (o_done) n_done++;
    if (o_tm_start) begin
      n_tms++;
      if (tq.size() == 0) chk("tm_start_extra", 1, 0);
      else begin
        e = tq.pop_front();
        chk("tm_bus", {o_tm_word, o_tm_ndoc, o_tm_topic}, e);
      end
    end
    if (o_samp_start) begin
      n_ss++;
      if (stag) chk("samp_after_bit1", 96'(cyc), 96'(b1_cyc + 1));
    end
    if (o_tm_topic_valid) begin
      if (ntq.size() == 0) chk("topic_valid_extra", 1, 0);
      else begin
        e = 96'(ntq.pop_front());
        chk("new_topic", 96'(o_tm_new_topic), e);
      end
    end
    if (o_z_wen) begin
      n_wen++;
      if (zq.size() == 0) chk("z_write_extra", 1, 0);
      else begin
        e = 96'(zq.pop_front());
        chk("z_write", {32'd0, 16'd0, o_tok_addr, o_z_wdata}, e);
      end
    end
  end

  task automatic expect_run(input int nt, input int ni);
    int k;
    logic [31:0] s, nz;
    k = 0;
    for (int it = 0; it < ni; it++)
      for (int t = 0; t < nt; t++) begin
        s = (k < samp_q.size()) ? samp_q[k] : 32'd0;
        k++;
        nz = (s < NT) ? s : mem_z[t];
        tq.push_back({mem_w[t], mem_d[t], mem_z[t]});
        ntq.push_back(nz);
        zq.push_back({32'(t), nz});
      end
  endtask

  task automatic snap();
    b_ren = n_ren; b_tms = n_tms; b_ss = n_ss; b_done = n_done; b_wen = n_wen;
  endtask

  task automatic kick(input int nt, input int ni);
    @(negedge clk);
    i_num_tokens = 16'(nt);
    i_num_iters  = 16'(ni);
    i_start      = 1'b1;
    start_cyc    = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    bit got;
    got = 1'b0;
    dcyc = -1;
    if (o_done) begin got = 1'b1; dcyc = cyc; end
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (o_done) begin got = 1'b1; dcyc = cyc; end
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic set_vdel(input int d);
    for (int i = 0; i < NT; i++) vdel[i] = d;
  endtask

  initial begin
    int dc;
    bit hit;
    set_vdel(2);
    for (int i = 0; i < NT; i++) ddel[i] = 3;
    mem_w[0] = 3; mem_d[0] = 1; mem_z[0] = 0;
    mem_w[1] = 5; mem_d[1] = 2; mem_z[1] = 2;
    mem_w[2] = 7; mem_d[2] = 4; mem_z[2] = 1;
    for (int i = 3; i < 8; i++) begin mem_w[i] = 0; mem_d[i] = 0; mem_z[i] = 0; end
    repeat (3) @(negedge clk);
    chk("reset_ctl", {o_busy, o_done, o_err, o_tok_ren, o_z_wen, o_tm_start, o_samp_start, o_tm_topic_valid}, 0);
    chk("reset_cnt", {o_tok_cnt, o_iter_cnt, o_tok_addr, o_z_wdata}, 0);
    rst = 1'b0;

    // Two tokens, one pass
    samp_q = '{32'd1, 32'd3};
    snap(); expect_run(2, 1); kick(2, 1); wait_done("basic", dc);
    repeat (2) @(negedge clk);
    chk("basic_tm_starts", 96'(n_tms - b_tms), 2);
    chk("basic_samp_starts", 96'(n_ss - b_ss), 2);
    chk("basic_done_pulses", 96'(n_done - b_done), 1);
    chk("basic_iter_cnt", 96'(o_iter_cnt), 1);
    chk("basic_writes_left", 96'(zq.size()), 0);

    // Zero tokens: straight to FIN
    snap(); kick(0, 5); wait_done("zero", dc);
    chk("zero_done_latency", 96'(dc - start_cyc), 2);
    repeat (2) @(negedge clk);
    chk("zero_activity", {32'(n_ren - b_ren), 32'(n_tms - b_tms), 32'(n_wen - b_wen)}, 0);

    // Staggered valids, order 3,0,2,1
    vdel[3] = 1; vdel[0] = 2; vdel[2] = 3; vdel[1] = 4;
    samp_q = '{32'd2};
    stag = 1'b1;
    snap(); expect_run(1, 1); kick(1, 1); wait_done("stagger", dc);
    stag = 1'b0;
    chk("stagger_samp_starts", 96'(n_ss - b_ss), 1);

    // All valids in the START cycle
    set_vdel(0);
    samp_q = '{32'd3};
    snap(); expect_run(1, 1); kick(1, 1); wait_done("immediate", dc);
    chk("immediate_writes", 96'(n_wen - b_wen), 1);
    set_vdel(2);

    // Out-of-range sample keeps the old topic
    mem_z[0] = 2;
    samp_q = '{32'd7};
    snap(); expect_run(1, 1); kick(1, 1); wait_done("err", dc);
    chk("err_set", 96'(o_err), 1);
    repeat (5) @(negedge clk);
    chk("err_sticky", 96'(o_err), 1);
    mem_z[0] = 0;

    // Three tokens, two passes
    samp_q = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2};
    snap(); expect_run(3, 2); kick(3, 2);
    chk("err_cleared", 96'(o_err), 0);
    wait_done("multi", dc);
    chk("multi_writes_at_done", 96'(n_wen - b_wen), 6);
    chk("multi_iter_cnt", 96'(o_iter_cnt), 2);
    chk("multi_writes_left", 96'(zq.size()), 0);

    // Reset while the sampler is busy
    slat = 6;
    samp_q = '{32'd1};
    expect_run(2, 1); kick(2, 1);
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (o_samp_start) hit = 1'b1;
    end
    if (!hit) chk("rst_samp_timeout", 0, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctl", {o_busy, o_done, o_err, o_tok_ren, o_z_wen, o_tm_start, o_samp_start, o_tm_topic_valid}, 0);
    chk("rst_mid_cnt", {o_tok_cnt, o_iter_cnt, o_z_wdata, o_tm_word}, 0);
    rst = 1'b0;
    tq.delete(); ntq.delete(); zq.delete();
    snap();
    repeat (12) @(negedge clk);
    chk("rst_no_write", 96'(n_wen - b_wen), 0);
    samp_q.delete();
    slat = 1;

    // i_start while busy is ignored
    samp_q = '{32'd1, 32'd2};
    snap(); expect_run(2, 1); kick(2, 1);
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (o_tm_start && o_tok_cnt == 16'd1) hit = 1'b1;
    end
    if (!hit) chk("busy_tok1_timeout", 0, 1);
    i_num_tokens = 16'd0; i_num_iters = 16'd0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_start_ignored", {o_busy, o_tok_cnt}, {1'b1, 16'd1});
    wait_done("busy", dc);
    chk("busy_iter_cnt", 96'(o_iter_cnt), 1);
    chk("busy_writes", 96'(n_wen - b_wen), 2);
    chk("busy_writes_left", 96'(zq.size()), 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
